// File: rtl/ex_mem_pipeline_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipeline_reg_pkg
// Shared definitions for the pipeline registers (ID/EX, EX/MEM, MEM/WB):
//   - default field widths
//   - ctrl_t : control bundle {valid, regWrite, memRead, memWrite, memToReg}
//   - BUBBLE : all-zero control bundle loaded on flush / invalid slots
//   - make_ctrl() : builds a bundle, collapsing to BUBBLE when not valid
// ---------------------------------------------------------------------------
package ex_mem_pipeline_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int CNT_W_DEF  = 32;

    typedef struct packed {
        logic valid;
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memToReg;
    } ctrl_t;

    localparam int    CTRL_W = $bits(ctrl_t);
    localparam ctrl_t BUBBLE = '0;

    // An invalid slot must never carry side-effecting control bits, so the
    // whole bundle collapses to BUBBLE rather than just clearing valid.
    function automatic ctrl_t make_ctrl(input logic valid,
                                        input logic regWrite,
                                        input logic memRead,
                                        input logic memWrite,
                                        input logic memToReg);
        ctrl_t c;
        if (!valid) begin
            c = BUBBLE;
        end else begin
            c.valid    = 1'b1;
            c.regWrite = regWrite;
            c.memRead  = memRead;
            c.memWrite = memWrite;
            c.memToReg = memToReg;
        end
        return c;
    endfunction

endpackage

// File: rtl/ex_mem_pipeline_reg_if.sv
// ---------------------------------------------------------------------------
// ex_mem_pipeline_reg_if
// Bundles the EX-side inputs (stall/flush, ID_EX control, datapath fields)
// and the registered EX/MEM outputs of the EX/MEM pipeline register.
//   master : the surrounding pipeline (drives EX side, observes EX/MEM side)
//   slave  : the EX/MEM register itself
// ---------------------------------------------------------------------------
interface ex_mem_pipeline_reg_if #(
    parameter int DATA_W = ex_mem_pipeline_reg_pkg::DATA_W_DEF,
    parameter int REG_W  = ex_mem_pipeline_reg_pkg::REG_W_DEF,
    parameter int CNT_W  = ex_mem_pipeline_reg_pkg::CNT_W_DEF
) ();

    // EX side
    logic              stall;
    logic              flush;
    logic              ID_EX_valid;
    logic              ID_EX_regWrite;
    logic              ID_EX_memRead;
    logic              ID_EX_memWrite;
    logic              ID_EX_memToReg;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  EX_rd;
    logic [REG_W-1:0]  EX_rt;

    // EX/MEM side
    logic              EX_MEM_valid;
    logic              EX_MEM_regWrite;
    logic              EX_MEM_memRead;
    logic              EX_MEM_memWrite;
    logic              EX_MEM_memToReg;
    logic [DATA_W-1:0] EX_MEM_aluResult;
    logic [DATA_W-1:0] EX_MEM_storeData;
    logic [REG_W-1:0]  EX_MEM_rd;
    logic [REG_W-1:0]  EX_MEM_rt;
    logic [CNT_W-1:0]  valid_count;

    modport master (
        output stall, flush,
        output ID_EX_valid, ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite, ID_EX_memToReg,
        output ALU_result, store_data, EX_rd, EX_rt,
        input  EX_MEM_valid, EX_MEM_regWrite, EX_MEM_memRead, EX_MEM_memWrite, EX_MEM_memToReg,
        input  EX_MEM_aluResult, EX_MEM_storeData, EX_MEM_rd, EX_MEM_rt, valid_count
    );

    modport slave (
        input  stall, flush,
        input  ID_EX_valid, ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite, ID_EX_memToReg,
        input  ALU_result, store_data, EX_rd, EX_rt,
        output EX_MEM_valid, EX_MEM_regWrite, EX_MEM_memRead, EX_MEM_memWrite, EX_MEM_memToReg,
        output EX_MEM_aluResult, EX_MEM_storeData, EX_MEM_rd, EX_MEM_rt, valid_count
    );

endinterface

// File: rtl/ex_mem_pipeline_reg_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_reg
// Parameterised control-bundle flop shared by the pipeline registers.
// Per-edge priority: reset > flush > stall > load. Both reset and flush load
// the all-zero bubble.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_stall        : hold current contents
//   i_flush        : load bubble (overrides stall)
//   i_d            : next control bundle
//   o_q            : registered control bundle
// ---------------------------------------------------------------------------
module pipe_ctrl_reg
    import ex_mem_pipeline_reg_pkg::*;
#(
    parameter int W = CTRL_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_stall,
    input  logic         i_flush,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset)       r_q <= '0;
        else if (i_flush)  r_q <= '0;
        else if (!i_stall) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_mem_pipeline_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipeline_reg
// EX/MEM pipeline register. Captures the ALU result, store data, rd/rt and
// the control bundle each edge, with reset > flush > stall > load priority,
// and counts valid instructions handed to MEM.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_reset : synchronous active-high reset (clears everything incl. count)
//   bus     : ex_mem_pipeline_reg_if.slave -- stall/flush, EX inputs,
//             registered EX/MEM outputs and valid_count
// EX_MEM_regWrite/EX_MEM_rd feed forwarding; EX_MEM_rt goes on to MEM/WB.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ex_mem_pipeline_reg
    import ex_mem_pipeline_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    ex_mem_pipeline_reg_if.slave  bus
);

    ctrl_t             w_ctrl_d;
    logic [CTRL_W-1:0] w_ctrl_q;
    ctrl_t             w_ctrl;
    logic [REG_W-1:0]  w_rd_d;
    logic [REG_W-1:0]  w_rt_d;
    logic              w_load_valid;

    logic [DATA_W-1:0] r_aluResult;
    logic [DATA_W-1:0] r_storeData;
    logic [REG_W-1:0]  r_rd;
    logic [REG_W-1:0]  r_rt;
    logic [CNT_W-1:0]  r_count;

    // Invalid slots become bubbles; rd/rt are zeroed too so a bubble can
    // never match in the forwarding or load-hazard comparators. rd=0 from a
    // valid instruction is passed through untouched.
    assign w_ctrl_d = make_ctrl(bus.ID_EX_valid, bus.ID_EX_regWrite,
                                bus.ID_EX_memRead, bus.ID_EX_memWrite,
                                bus.ID_EX_memToReg);
    assign w_rd_d   = bus.ID_EX_valid ? bus.EX_rd : '0;
    assign w_rt_d   = bus.ID_EX_valid ? bus.EX_rt : '0;

    pipe_ctrl_reg #(.W(CTRL_W)) u_ctrl (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_stall (bus.stall),
        .i_flush (bus.flush),
        .i_d     (w_ctrl_d),
        .o_q     (w_ctrl_q)
    );

    assign w_ctrl = ctrl_t'(w_ctrl_q);

    // Datapath fields: same priority as the control bundle. Flush zeroes the
    // data too so a bubble is fully deterministic.
    always_ff @(posedge i_clk) begin
        if (i_reset || bus.flush) begin
            r_aluResult <= '0;
            r_storeData <= '0;
            r_rd        <= '0;
            r_rt        <= '0;
        end else if (!bus.stall) begin
            r_aluResult <= bus.ALU_result;
            r_storeData <= bus.store_data;
            r_rd        <= w_rd_d;
            r_rt        <= w_rt_d;
        end
    end

    // Counts only real instructions actually loaded (not stalled/flushed);
    // wraps naturally at 2^CNT_W.
    assign w_load_valid = !bus.flush && !bus.stall && bus.ID_EX_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset)           r_count <= '0;
        else if (w_load_valid) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.EX_MEM_valid     = w_ctrl.valid;
    assign bus.EX_MEM_regWrite  = w_ctrl.regWrite;
    assign bus.EX_MEM_memRead   = w_ctrl.memRead;
    assign bus.EX_MEM_memWrite  = w_ctrl.memWrite;
    assign bus.EX_MEM_memToReg  = w_ctrl.memToReg;
    assign bus.EX_MEM_aluResult = r_aluResult;
    assign bus.EX_MEM_storeData = r_storeData;
    assign bus.EX_MEM_rd        = r_rd;
    assign bus.EX_MEM_rt        = r_rt;
    assign bus.valid_count      = r_count;

endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipeline_reg
// Directed bench for ex_mem_pipeline_reg. Two instances share one stimulus:
// the default CNT_W=32 instance and a CNT_W=4 instance for counter wrap.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipeline_reg;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ex_mem_pipeline_reg_if #(.DATA_W(32), .REG_W(5), .CNT_W(32)) bus  ();
    ex_mem_pipeline_reg_if #(.DATA_W(32), .REG_W(5), .CNT_W(4))  bus4 ();

    ex_mem_pipeline_reg #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    ex_mem_pipeline_reg #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut4 (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus4)
    );

    assign bus4.stall          = bus.stall;
    assign bus4.flush          = bus.flush;
    assign bus4.ID_EX_valid    = bus.ID_EX_valid;
    assign bus4.ID_EX_regWrite = bus.ID_EX_regWrite;
    assign bus4.ID_EX_memRead  = bus.ID_EX_memRead;
    assign bus4.ID_EX_memWrite = bus.ID_EX_memWrite;
    assign bus4.ID_EX_memToReg = bus.ID_EX_memToReg;
    assign bus4.ALU_result     = bus.ALU_result;
    assign bus4.store_data     = bus.store_data;
    assign bus4.EX_rd          = bus.EX_rd;
    assign bus4.EX_rt          = bus.EX_rt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic m2r, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [4:0] rt);
        bus.ID_EX_valid    = v;
        bus.ID_EX_regWrite = rw;
        bus.ID_EX_memRead  = mr;
        bus.ID_EX_memWrite = mw;
        bus.ID_EX_memToReg = m2r;
        bus.ALU_result     = alu;
        bus.store_data     = sd;
        bus.EX_rd          = rd;
        bus.EX_rt          = rt;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},     bus.EX_MEM_valid,     0);
        chk({tag, ".regWrite"},  bus.EX_MEM_regWrite,  0);
        chk({tag, ".memRead"},   bus.EX_MEM_memRead,   0);
        chk({tag, ".memWrite"},  bus.EX_MEM_memWrite,  0);
        chk({tag, ".memToReg"},  bus.EX_MEM_memToReg,  0);
        chk({tag, ".aluResult"}, bus.EX_MEM_aluResult, 0);
        chk({tag, ".storeData"}, bus.EX_MEM_storeData, 0);
        chk({tag, ".rd"},        bus.EX_MEM_rd,        0);
        chk({tag, ".rt"},        bus.EX_MEM_rt,        0);
        chk({tag, ".count"},     bus.valid_count,      0);
        chk({tag, ".count4"},    bus4.valid_count,     0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // 1. reset with every input high
        reset = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        drive(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 5'h1F);
        tick(); tick();
        chk_zero("reset");

        // 2. normal valid load, 1-cycle latency
        reset = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        drive(1, 1, 0, 0, 0, 32'h0000_00A5, 32'h0000_1234, 5'd8, 5'd3);
        tick();
        chk("load.alu",   bus.EX_MEM_aluResult, 32'hA5);
        chk("load.rd",    bus.EX_MEM_rd,        8);
        chk("load.rt",    bus.EX_MEM_rt,        3);
        chk("load.rw",    bus.EX_MEM_regWrite,  1);
        chk("load.valid", bus.EX_MEM_valid,     1);
        chk("load.sd",    bus.EX_MEM_storeData, 32'h1234);
        chk("load.mr",    bus.EX_MEM_memRead,   0);
        chk("load.count", bus.valid_count,      1);

        // outputs are flops: input change mid-cycle must not leak through
        drive(1, 0, 1, 1, 1, 32'hFFFF_0000, 32'h0, 5'd31, 5'd30);
        #2;
        chk("nocomb.alu", bus.EX_MEM_aluResult, 32'hA5);
        chk("nocomb.rd",  bus.EX_MEM_rd,        8);

        // 3. stall for 3 cycles while inputs change
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 1, 32'h100 + i, 32'h200 + i, 5'(i + 20), 5'(i + 10));
            tick();
            chk("stall.alu",   bus.EX_MEM_aluResult, 32'hA5);
            chk("stall.rd",    bus.EX_MEM_rd,        8);
            chk("stall.rw",    bus.EX_MEM_regWrite,  1);
            chk("stall.mw",    bus.EX_MEM_memWrite,  0);
            chk("stall.count", bus.valid_count,      1);
        end

        // 4. flush overrides stall with a valid load pending
        bus.flush = 1'b1;
        drive(1, 1, 1, 1, 1, 32'h77, 32'h88, 5'd9, 5'd4);
        tick();
        bus.flush = 1'b0; bus.stall = 1'b0;
        chk("flush.rw",    bus.EX_MEM_regWrite,  0);
        chk("flush.rd",    bus.EX_MEM_rd,        0);
        chk("flush.rt",    bus.EX_MEM_rt,        0);
        chk("flush.valid", bus.EX_MEM_valid,     0);
        chk("flush.alu",   bus.EX_MEM_aluResult, 0);
        chk("flush.sd",    bus.EX_MEM_storeData, 0);
        chk("flush.count", bus.valid_count,      1);

        // 5. invalid input loads a bubble (data passes through)
        drive(0, 1, 1, 1, 1, 32'h55, 32'h66, 5'd5, 5'd6);
        tick();
        chk("inv.rw",    bus.EX_MEM_regWrite,  0);
        chk("inv.mw",    bus.EX_MEM_memWrite,  0);
        chk("inv.mr",    bus.EX_MEM_memRead,   0);
        chk("inv.m2r",   bus.EX_MEM_memToReg,  0);
        chk("inv.rd",    bus.EX_MEM_rd,        0);
        chk("inv.rt",    bus.EX_MEM_rt,        0);
        chk("inv.valid", bus.EX_MEM_valid,     0);
        chk("inv.alu",   bus.EX_MEM_aluResult, 32'h55);
        chk("inv.count", bus.valid_count,      1);

        // rd=0 with regWrite passes through unmasked
        drive(1, 1, 0, 0, 0, 32'h11, 32'h0, 5'd0, 5'd2);
        tick();
        chk("r0.rw",    bus.EX_MEM_regWrite, 1);
        chk("r0.rd",    bus.EX_MEM_rd,       0);
        chk("r0.count", bus.valid_count,     2);

        // load: memRead + memToReg
        drive(1, 1, 1, 0, 1, 32'h100, 32'h0, 5'd10, 5'd10);
        tick();
        chk("ld.mr",  bus.EX_MEM_memRead,  1);
        chk("ld.m2r", bus.EX_MEM_memToReg, 1);
        chk("ld.mw",  bus.EX_MEM_memWrite, 0);
        chk("ld.rt",  bus.EX_MEM_rt,       10);

        // store
        drive(1, 0, 0, 1, 0, 32'h200, 32'hDEAD_BEEF, 5'd0, 5'd7);
        tick();
        chk("st.mw",    bus.EX_MEM_memWrite,  1);
        chk("st.rw",    bus.EX_MEM_regWrite,  0);
        chk("st.sd",    bus.EX_MEM_storeData, 32'hDEAD_BEEF);
        chk("st.count", bus.valid_count,      4);

        // plain flush without stall
        bus.flush = 1'b1;
        drive(1, 1, 0, 0, 0, 32'h300, 32'h0, 5'd12, 5'd1);
        tick();
        bus.flush = 1'b0;
        chk("flush2.valid", bus.EX_MEM_valid, 0);
        chk("flush2.count", bus.valid_count,  4);

        // 6. counter wrap on the CNT_W=4 instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wrap.start", bus4.valid_count, 0);
        for (int i = 1; i <= 17; i++) begin
            drive(1, 1, 0, 0, 0, 32'(i), 32'(i * 3), 5'(i), 5'(i + 1));
            tick();
            if (i == 15) chk("wrap.15", bus4.valid_count, 15);
            if (i == 16) chk("wrap.16", bus4.valid_count, 0);
        end
        chk("wrap.17",   bus4.valid_count,      1);
        chk("wrap.big",  bus.valid_count,       17);
        chk("wrap.alu",  bus.EX_MEM_aluResult,  17);
        chk("wrap.rd",   bus.EX_MEM_rd,         17);

        // reset mid-stream with a valid load pending
        reset = 1'b1;
        drive(1, 1, 1, 1, 1, 32'hABCD, 32'h1234, 5'd19, 5'd18);
        tick();
        chk_zero("midrst");
        reset = 1'b0;
        tick();
        chk("post.count",  bus.valid_count,  1);
        chk("post.count4", bus4.valid_count, 1);
        chk("post.alu",    bus.EX_MEM_aluResult, 32'hABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
